ssd1331_spi_tx: RTL and testbench

SPI byte transmitter for the SSD1331 OLED controller, sitting directly downstream of `clock_divider`.
- Requests the divided clock from the divider through `o_DIV_EN` and follows its edges to generate SCLK.
- Shifts one `DATA_W`-bit word MSB-first on MOSI, with D/C# and CS# framing.
- The init/pixel sequencer above it hands over words through a ready/start handshake.

---
 rtl/ssd1331_spi_tx.sv | 107 ++++++++++
 tb/tb_ssd1331_spi_tx.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/ssd1331_spi_tx.sv
`default_nettype none
// ssd1331_spi_tx: MSB-first SPI word transmitter for the SSD1331 panel.
// SCLK follows the clock_divider output, two i_CLK edges late.
module ssd1331_spi_tx #(
  parameter int DATA_W = 8
) (
  input  logic              i_CLK,
  input  logic              i_RST,
  input  logic              i_CLK_DIV,
  output logic              o_DIV_EN,
  input  logic              i_START,
  input  logic [DATA_W-1:0] i_DATA,
  input  logic              i_DC,
  output logic              o_READY,
  output logic              o_DONE,
  output logic              o_SCLK,
  output logic              o_MOSI,
  output logic              o_CS_N,
  output logic              o_DC
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t            state;
  logic              d1;
  logic              d2;
  logic [DATA_W-1:0] sr;
  logic [CNT_W-1:0]  cnt;
  logic              rise;
  logic              fall;

  assign rise     = d1 & ~d2;
  assign fall     = ~d1 & d2;
  assign o_READY  = (state == IDLE);
  assign o_DIV_EN = (state != IDLE);

  always_ff @(posedge i_CLK or negedge i_RST) begin
    if (!i_RST) begin
      state  <= IDLE;
      d1     <= 1'b0;
      d2     <= 1'b0;
      sr     <= '0;
      cnt    <= '0;
      o_DONE <= 1'b0;
      o_SCLK <= 1'b1;
      o_MOSI <= 1'b0;
      o_CS_N <= 1'b1;
      o_DC   <= 1'b0;
    end else begin
      d1     <= i_CLK_DIV;
      d2     <= d1;
      o_DONE <= 1'b0;
      case (state)
        IDLE: begin
          if (i_START) begin
            sr     <= i_DATA;
            o_DC   <= i_DC;
            o_CS_N <= 1'b0;
            o_SCLK <= 1'b1;
            cnt    <= '0;
            state  <= SETUP;
          end
        end
        SETUP: begin
          if (fall) begin
            o_SCLK <= 1'b0;
            o_MOSI <= sr[DATA_W-1];
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          if (rise) begin
            o_SCLK <= 1'b1;
            if (cnt == LAST) begin
              state <= HOLD;
            end
          end else if (fall) begin
            // Next bit comes from the pre-shift word, so MOSI leads the shifted register.
            o_SCLK <= 1'b0;
            sr     <= sr << 1;
            cnt    <= cnt + 1'b1;
            o_MOSI <= sr[DATA_W-2];
          end
        end
        HOLD: begin
          if (fall) begin
            o_CS_N <= 1'b1;
            o_MOSI <= 1'b0;
            o_DONE <= 1'b1;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ssd1331_spi_tx.sv
`default_nettype none
// tb_ssd1331_spi_tx: scoreboard bench for 8-bit and 16-bit transmitters sharing one divided clock.
module tb_ssd1331_spi_tx;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clk_div = 1'b1;
  logic [1:0] dcnt = 2'd0;

  logic       start8 = 1'b0;
  logic [7:0] data8 = 8'd0;
  logic       dcin8 = 1'b0;
  logic div_en8, ready8, done8, sclk8, mosi8, cs_n8, dc8;

  logic        start16 = 1'b0;
  logic [15:0] data16 = 16'd0;
  logic        dcin16 = 1'b0;
  logic div_en16, ready16, done16, sclk16, mosi16, cs_n16, dc16;

  int errors = 0;
  int checks = 0;

  logic [8:0]  q8[$];
  logic [15:0] q16[$];

  always #5 clk = ~clk;

  // Divided clock, period 4 i_CLK cycles (2 high, 2 low).
  always @(posedge clk) begin
    dcnt    <= dcnt + 2'd1;
    clk_div <= ~dcnt[1];
  end

  ssd1331_spi_tx #(.DATA_W(8)) dut8 (
    .i_CLK(clk), .i_RST(rst_n), .i_CLK_DIV(clk_div), .o_DIV_EN(div_en8),
    .i_START(start8), .i_DATA(data8), .i_DC(dcin8), .o_READY(ready8),
    .o_DONE(done8), .o_SCLK(sclk8), .o_MOSI(mosi8), .o_CS_N(cs_n8), .o_DC(dc8)
  );

  ssd1331_spi_tx #(.DATA_W(16)) dut16 (
    .i_CLK(clk), .i_RST(rst_n), .i_CLK_DIV(clk_div), .o_DIV_EN(div_en16),
    .i_START(start16), .i_DATA(data16), .i_DC(dcin16), .o_READY(ready16),
    .o_DONE(done16), .o_SCLK(sclk16), .o_MOSI(mosi16), .o_CS_N(cs_n16), .o_DC(dc16)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor for the 8-bit instance.
  int rises8 = 0, cslen8 = 0, dones8 = 0;
  logic [7:0] bits8 = 8'd0;
  logic prev8 = 1'b1, dcbad8 = 1'b0;
  logic [8:0] e8;
  always @(negedge clk) begin
    if (done8) begin
      dones8++;
      if (q8.size() == 0) begin
        check("unexpected_done8", 32'd1, 32'd0);
      end else begin
        e8 = q8.pop_front();
        check("word8", 32'(bits8), 32'(e8[7:0]));
        check("rises8", 32'(rises8), 32'd8);
        check("dc8", 32'({dcbad8, dc8}), 32'({1'b0, e8[8]}));
        check("cslen8_range", 32'((cslen8 >= 33) && (cslen8 <= 36)), 32'd1);
        check("done_cs_high8", 32'(cs_n8), 32'd1);
      end
      rises8 = 0; cslen8 = 0; bits8 = '0; dcbad8 = 1'b0;
    end else if (cs_n8) begin
      rises8 = 0; cslen8 = 0; bits8 = '0; dcbad8 = 1'b0;
    end else begin
      cslen8++;
      if (sclk8 && !prev8) begin
        rises8++;
        bits8 = {bits8[6:0], mosi8};
      end
      if (q8.size() > 0 && dc8 !== q8[0][8]) dcbad8 = 1'b1;
    end
    prev8 = sclk8;
  end

  // Monitor for the 16-bit instance.
  int rises16 = 0, dones16 = 0;
  logic [15:0] bits16 = 16'd0;
  logic prev16 = 1'b1;
  logic [15:0] e16;
  always @(negedge clk) begin
    if (done16) begin
      dones16++;
      if (q16.size() == 0) begin
        check("unexpected_done16", 32'd1, 32'd0);
      end else begin
        e16 = q16.pop_front();
        check("word16", 32'(bits16), 32'(e16));
        check("rises16", 32'(rises16), 32'd16);
      end
      rises16 = 0; bits16 = '0;
    end else if (cs_n16) begin
      rises16 = 0; bits16 = '0;
    end else if (sclk16 && !prev16) begin
      rises16++;
      bits16 = {bits16[14:0], mosi16};
    end
    prev16 = sclk16;
  end

  task automatic send8(input logic [7:0] d, input logic dc, input logic expect_it);
    int n;
    n = 0;
    while (!ready8 && n < 200) begin
      @(negedge clk);
      n++;
    end
    start8 = 1'b1; data8 = d; dcin8 = dc;
    if (expect_it) q8.push_back({dc, d});
    @(negedge clk);
    start8 = 1'b0;
    check("accept8 rdy/cs/en", 32'({ready8, cs_n8, div_en8}), 32'b001);
  endtask

  task automatic wait_done8();
    int n;
    n = 0;
    while (!done8 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!done8) check("timeout_done8", 32'd0, 32'd1);
  endtask

  task automatic wait_rises8(input int r);
    int n;
    n = 0;
    while (rises8 < r && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (rises8 < r) check("timeout_rises8", 32'(rises8), 32'(r));
  endtask

  int d0;
  initial begin
    // Reset held with a pending start: nothing may move.
    start8 = 1'b1; data8 = 8'hFF; start16 = 1'b1; data16 = 16'hFFFF;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("reset_outs8", 32'({sclk8, cs_n8, mosi8, dc8, ready8, done8, div_en8}), 32'b1100100);
    end
    check("reset_outs16", 32'({sclk16, cs_n16, mosi16, dc16, ready16, done16, div_en16}), 32'b1100100);
    start8 = 1'b0; start16 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", 32'({ready8, cs_n8, ready16}), 32'b111);

    // Command byte.
    send8(8'hAF, 1'b0, 1'b1);
    wait_done8();
    @(negedge clk);
    check("ready_after_done", 32'(ready8), 32'd1);

    // Back-to-back data words, second started in the DONE cycle.
    d0 = dones8;
    send8(8'h5A, 1'b1, 1'b1);
    wait_done8();
    check("b2b cs high at done", 32'({cs_n8, ready8}), 32'b11);
    start8 = 1'b1; data8 = 8'hC3; dcin8 = 1'b1;
    q8.push_back({1'b1, 8'hC3});
    @(negedge clk);
    start8 = 1'b0;
    check("b2b cs low next cycle", 32'({cs_n8, ready8, div_en8}), 32'b001);
    wait_done8();
    repeat (3) @(negedge clk);
    check("b2b done count", 32'(dones8 - d0), 32'd2);
    check("b2b dc held in idle", 32'(dc8), 32'd1);

    // Start while busy is ignored.
    d0 = dones8;
    send8(8'h00, 1'b0, 1'b1);
    wait_rises8(3);
    start8 = 1'b1; data8 = 8'hFF; dcin8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    wait_done8();
    repeat (60) @(negedge clk);
    check("busy single done", 32'(dones8 - d0), 32'd1);
    check("busy no second xfer", 32'({ready8, cs_n8}), 32'b11);

    // Reset in the middle of a byte.
    send8(8'hFF, 1'b0, 1'b0);
    wait_rises8(3);
    #2 rst_n = 1'b0;
    #1 check("midreset cs/sclk/en/rdy", 32'({cs_n8, sclk8, div_en8, ready8}), 32'b1101);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send8(8'h81, 1'b0, 1'b1);
    wait_done8();

    // Wide word on the 16-bit instance.
    d0 = dones16;
    @(negedge clk);
    start16 = 1'b1; data16 = 16'hA55A; dcin16 = 1'b1;
    q16.push_back(16'hA55A);
    @(negedge clk);
    start16 = 1'b0;
    check("accept16 rdy/cs/en", 32'({ready16, cs_n16, div_en16}), 32'b001);
    for (int n = 0; n < 300 && !done16; n++) @(negedge clk);
    if (!done16) check("timeout_done16", 32'd0, 32'd1);
    repeat (20) @(negedge clk);
    check("wide done count", 32'(dones16 - d0), 32'd1);
    check("wide dc latched", 32'(dc16), 32'd1);

    check("queue8 drained", 32'(q8.size()), 32'd0);
    check("queue16 drained", 32'(q16.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
